operand_fetch_ctrl: RTL and testbench
=====================================

// Module: operand_fetch_ctrl
// PURPOSE
//  Sequencer for the CPU operand-fetch datapath. Given a decoded double-operand instruction (As/Ad modes),
//  walks extension-word fetch, source read, destination read, execute and memory write-back, driving
//  the datapath's mux/latch controls (srcM/srcL, dstM/dstL, AddrM/AddrL, IdxM) and the memory strobes.
//  Sits between the instruction decoder and the operand-fetch datapath / memory bus; stalls on mem_wait.
// PARAMETERS
//  none (fixed 16-bit MSP430 operand path; absolute/symbolic/CG modes resolved by the decoder)
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  start     in   1  decoded instruction valid; sampled only in IDLE
//  As        in   2  source mode: 00 Rn, 01 X(Rn), 10 @Rn, 11 @Rn+ (@PC+ = immediate)
//  Ad        in   1  dest mode: 0 Rn, 1 X(Rn)
//  cg        in   1  source is constant generator: treat as As=00 regardless of As
//  no_wb     in   1  instruction writes no result (CMP/BIT)
//  mem_wait  in   1  memory not ready this cycle; hold state, suppress latches
//  srcM,srcL,dstM,dstL,IdxM,AddrL  out 1  datapath controls (see BEHAVIOUR)
//  AddrM     out  2  datapath MAB select: 0 Addr, 2 Rsrc
//  mab_pc    out  1  top-level MAB mux selects PC (extension-word fetch)
//  mem_rd    out  1  memory read strobe;  mem_wr  out 1  memory write strobe
//  pc_inc    out  1  PC += 2 this cycle;  src_inc out 1  source register post-increment
//  exec      out  1  operands valid to function unit this cycle
//  reg_wb    out  1  register-file result write this cycle
//  busy      out  1  state != IDLE;  done  out 1  one-cycle pulse in final state of an instruction
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE immediately; every output 0 (AddrM=00) while in reset and in IDLE.
//  - States: IDLE, SRC_EXT, SRC_RD, DST_EXT, DST_RD, EXEC, WB. One state per cycle unless stalled.
//  - IDLE + start: sm = cg?00:As. Next = SRC_EXT if sm=01, SRC_RD if sm=1x, else DST_EXT if Ad, else EXEC.
//    start while busy is ignored (decoder holds it until done).
//  - SRC_EXT: mab_pc=1, mem_rd=1, AddrL=1, IdxM=0, AddrM=0 (Addr<=MDB+Rsrc), pc_inc=1 -> SRC_RD.
//  - SRC_RD: mem_rd=1, srcL=1; AddrM=0 if sm=01 else 2; src_inc=1 if sm=11 -> DST_EXT if Ad else EXEC.
//  - DST_EXT: mab_pc=1, mem_rd=1, AddrL=1, IdxM=1, AddrM=0 (Addr<=MDB+Rdst), pc_inc=1 -> DST_RD.
//  - DST_RD: AddrM=0, mem_rd=1, dstL=1, dstM=1 (dst<=MDB) -> EXEC.
//  - EXEC: exec=1; srcM=(sm!=00); dstM=Ad; reg_wb=(!Ad & !no_wb); AddrM=0.
//    -> WB if Ad & !no_wb, else IDLE with done=1 this cycle.
//  - WB: AddrM=0, mem_wr=1; dstM=1, srcM=(sm!=00) held so result stays valid; done=1 -> IDLE.
//  - sm, Ad, no_wb captured into internal regs on start; input changes mid-instruction are ignored.
//  - mem_wait=1 in SRC_EXT/SRC_RD/DST_EXT/DST_RD/WB: state held; srcL, dstL, AddrL, pc_inc, src_inc,
//    done forced 0; mem_rd/mem_wr, AddrM, mab_pc held asserted. EXEC ignores mem_wait.
//  - Each latch/increment strobe is asserted exactly once per state, on the completing (non-wait) cycle.
//  - Latency (no waits), start cycle T: Rn,Rn done T+1; @Rn,Rn T+2; X(Rn),Rn T+3; Rn,X(Rn) T+4;
//    X(Rn),X(Rn) T+6 (max). no_wb removes WB (-1 cycle).
//  - rst_n low mid-instruction: aborts at once; no partial strobe after reset; next start begins clean.
// TESTING
//  - Reset: rst_n=0 asynchronously mid-DST_RD -> outputs 0 same cycle, busy=0; start after release
//    with As=00,Ad=0 -> exec,reg_wb,done at T+1 only.
//  - As=01,Ad=1 (MOV X(R5),Y(R6)), no waits -> states SRC_EXT,SRC_RD,DST_EXT,DST_RD,EXEC,WB; pc_inc twice;
//    IdxM 0 then 1; mem_wr at T+6 with AddrM=0; done at T+6.
//  - As=11 (@R4+),Ad=0 -> SRC_RD with AddrM=2, srcL=1, src_inc=1 once; EXEC srcM=1, reg_wb=1; done T+2.
//  - mem_wait=1 for 3 cycles in SRC_RD -> state holds, srcL/src_inc 0 during wait, single srcL pulse
//    after release; total latency +3.
//  - CMP X(R7),&ADDR form (As=01,Ad=1,no_wb=1) -> no WB state, mem_wr never asserted, done in EXEC (T+5).
//  - cg=1,As=11,Ad=0 -> treated as register: no mem_rd, no src_inc, srcM=0, done at T+1; start held
//    high during busy never restarts a sequence.

Source files
------------

// File: rtl/operand_fetch_ctrl.sv
// Operand-fetch sequencer for a double-operand instruction: walks extension-word
// fetch, source read, destination read, execute and write-back while driving datapath controls.
module operand_fetch_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] As,
    input  logic       Ad,
    input  logic       cg,
    input  logic       no_wb,
    input  logic       mem_wait,
    output logic       srcM,
    output logic       srcL,
    output logic       dstM,
    output logic       dstL,
    output logic       IdxM,
    output logic       AddrL,
    output logic [1:0] AddrM,
    output logic       mab_pc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       pc_inc,
    output logic       src_inc,
    output logic       exec,
    output logic       reg_wb,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SRC_EXT = 3'd1,
        S_SRC_RD  = 3'd2,
        S_DST_EXT = 3'd3,
        S_DST_RD  = 3'd4,
        S_EXEC    = 3'd5,
        S_WB      = 3'd6
    } state_t;

    localparam logic [1:0] SM_REG  = 2'b00;
    localparam logic [1:0] SM_IDX  = 2'b01;
    localparam logic [1:0] SM_AINC = 2'b11;

    localparam logic [1:0] ADDRM_ADDR = 2'd0;
    localparam logic [1:0] ADDRM_RSRC = 2'd2;

    state_t     state_q, state_d;
    logic [1:0] sm_q, sm_d;
    logic       ad_q, ad_d;
    logic       no_wb_q, no_wb_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sm_q    <= SM_REG;
            ad_q    <= 1'b0;
            no_wb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sm_q    <= sm_d;
            ad_q    <= ad_d;
            no_wb_q <= no_wb_d;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        sm_d    = sm_q;
        ad_d    = ad_q;
        no_wb_d = no_wb_q;
        srcM    = 1'b0;
        srcL    = 1'b0;
        dstM    = 1'b0;
        dstL    = 1'b0;
        IdxM    = 1'b0;
        AddrL   = 1'b0;
        AddrM   = ADDRM_ADDR;
        mab_pc  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        pc_inc  = 1'b0;
        src_inc = 1'b0;
        exec    = 1'b0;
        reg_wb  = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sm_d    = cg ? SM_REG : As;
                    ad_d    = Ad;
                    no_wb_d = no_wb;
                    if (sm_d == SM_IDX)       state_d = S_SRC_EXT;
                    else if (sm_d[1])         state_d = S_SRC_RD;
                    else if (Ad)              state_d = S_DST_EXT;
                    else                      state_d = S_EXEC;
                end
            end
            S_SRC_EXT: begin
                mab_pc = 1'b1;
                mem_rd = 1'b1;
                AddrL  = !mem_wait;
                pc_inc = !mem_wait;
                if (!mem_wait) state_d = S_SRC_RD;
            end
            S_SRC_RD: begin
                mem_rd  = 1'b1;
                srcL    = !mem_wait;
                AddrM   = (sm_q == SM_IDX) ? ADDRM_ADDR : ADDRM_RSRC;
                src_inc = (sm_q == SM_AINC) && !mem_wait;
                if (!mem_wait) state_d = ad_q ? S_DST_EXT : S_EXEC;
            end
            S_DST_EXT: begin
                mab_pc = 1'b1;
                mem_rd = 1'b1;
                IdxM   = 1'b1;
                AddrL  = !mem_wait;
                pc_inc = !mem_wait;
                if (!mem_wait) state_d = S_DST_RD;
            end
            S_DST_RD: begin
                mem_rd = 1'b1;
                dstM   = 1'b1;
                dstL   = !mem_wait;
                if (!mem_wait) state_d = S_EXEC;
            end
            S_EXEC: begin
                // Function unit is register-only, so this state never stalls on memory.
                exec   = 1'b1;
                srcM   = (sm_q != SM_REG);
                dstM   = ad_q;
                reg_wb = !ad_q && !no_wb_q;
                if (ad_q && !no_wb_q) begin
                    state_d = S_WB;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                mem_wr = 1'b1;
                dstM   = 1'b1;
                srcM   = (sm_q != SM_REG);
                done   = !mem_wait;
                if (!mem_wait) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Self-checking bench for operand_fetch_ctrl: table of instruction forms, directed
// corner sequences, and randomized instructions with memory stalls against a phase-list model.
module tb_operand_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] As;
    logic       Ad, cg, no_wb, mem_wait;
    logic       srcM, srcL, dstM, dstL, IdxM, AddrL;
    logic [1:0] AddrM;
    logic       mab_pc, mem_rd, mem_wr, pc_inc, src_inc, exec, reg_wb, busy, done;

    always #5 clk = ~clk;

    operand_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .As(As), .Ad(Ad), .cg(cg),
        .no_wb(no_wb), .mem_wait(mem_wait),
        .srcM(srcM), .srcL(srcL), .dstM(dstM), .dstL(dstL), .IdxM(IdxM),
        .AddrL(AddrL), .AddrM(AddrM), .mab_pc(mab_pc), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .pc_inc(pc_inc), .src_inc(src_inc), .exec(exec),
        .reg_wb(reg_wb), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic       srcM, srcL, dstM, dstL, IdxM, AddrL;
        logic [1:0] AddrM;
        logic       mab_pc, mem_rd, mem_wr, pc_inc, src_inc, exec, reg_wb, busy, done;
    } out_t;

    out_t got;
    assign got = {srcM, srcL, dstM, dstL, IdxM, AddrL, AddrM, mab_pc, mem_rd,
                  mem_wr, pc_inc, src_inc, exec, reg_wb, busy, done};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input out_t act, input out_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %05h required %05h", name, $time, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, req);
        end
    endtask

    // Expected per-cycle outputs of one instruction with no stalls.
    out_t phases[$];

    function automatic void build_phases(input logic [1:0] as_i, input logic ad_i,
                                         input logic cg_i, input logic nwb_i);
        logic [1:0] sm;
        out_t p;
        sm = cg_i ? 2'b00 : as_i;
        phases.delete();
        if (sm == 2'b01) begin
            p = '0; p.busy = 1; p.mab_pc = 1; p.mem_rd = 1; p.AddrL = 1; p.pc_inc = 1;
            phases.push_back(p);
        end
        if (sm != 2'b00) begin
            p = '0; p.busy = 1; p.mem_rd = 1; p.srcL = 1;
            p.AddrM   = (sm == 2'b01) ? 2'd0 : 2'd2;
            p.src_inc = (sm == 2'b11);
            phases.push_back(p);
        end
        if (ad_i) begin
            p = '0; p.busy = 1; p.mab_pc = 1; p.mem_rd = 1; p.AddrL = 1; p.IdxM = 1;
            p.pc_inc = 1;
            phases.push_back(p);
            p = '0; p.busy = 1; p.mem_rd = 1; p.dstL = 1; p.dstM = 1;
            phases.push_back(p);
        end
        p = '0; p.busy = 1; p.exec = 1; p.srcM = (sm != 2'b00); p.dstM = ad_i;
        p.reg_wb = !ad_i && !nwb_i;
        p.done   = !(ad_i && !nwb_i);
        phases.push_back(p);
        if (ad_i && !nwb_i) begin
            p = '0; p.busy = 1; p.mem_wr = 1; p.dstM = 1; p.srcM = (sm != 2'b00); p.done = 1;
            phases.push_back(p);
        end
    endfunction

    // mode: 0 no stalls, 1 stall on cycles flagged in mask, 2 random stalls.
    task automatic run_instr(input logic [1:0] as_i, input logic ad_i, input logic cg_i,
                             input logic nwb_i, input int mode, input logic [31:0] mask,
                             input bit hold_start, input bit scramble, input int abort_at,
                             output int done_cyc, output int n_pc, output int n_wr,
                             output int n_rd, output int n_srcl, output int n_sinc);
        int   idx;
        logic w;
        bit   stall;
        out_t ph, exp_o;
        done_cyc = 0; n_pc = 0; n_wr = 0; n_rd = 0; n_srcl = 0; n_sinc = 0;
        build_phases(as_i, ad_i, cg_i, nwb_i);
        start = 1'b1; As = as_i; Ad = ad_i; cg = cg_i; no_wb = nwb_i; mem_wait = 1'b0;
        @(negedge clk);
        check("idle_at_start", got, '0);
        @(posedge clk); #1;
        idx = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            case (mode)
                1:       w = mask[cyc];
                2:       w = ($urandom_range(0, 3) == 0);
                default: w = 1'b0;
            endcase
            mem_wait = w;
            start    = hold_start;
            if (scramble) begin
                As = 2'($urandom); Ad = 1'($urandom); cg = 1'($urandom); no_wb = 1'($urandom);
            end
            @(negedge clk);
            ph    = phases[idx];
            stall = w && (ph.mem_rd || ph.mem_wr);
            exp_o = ph;
            if (stall) begin
                exp_o.srcL = 0; exp_o.dstL = 0; exp_o.AddrL = 0;
                exp_o.pc_inc = 0; exp_o.src_inc = 0; exp_o.done = 0;
            end
            check("cycle_outputs", got, exp_o);
            n_pc   += int'(pc_inc);
            n_wr   += int'(mem_wr);
            n_rd   += int'(mem_rd);
            n_srcl += int'(srcL);
            n_sinc += int'(src_inc);
            if (done && done_cyc == 0) done_cyc = cyc;
            if (cyc == abort_at) begin
                #2 rst_n = 1'b0; start = 1'b0; mem_wait = 1'b0;
                #1 check("async_reset_outputs", got, '0);
                @(posedge clk); #1;
                @(posedge clk); #1 rst_n = 1'b1;
                return;
            end
            if (!stall) idx++;
            if (idx == phases.size()) start = 1'b0;
            @(posedge clk); #1;
            if (idx == phases.size()) break;
        end
        check_int("sequence_completes", idx, phases.size());
        start = 1'b0; mem_wait = 1'b0;
        @(negedge clk);
        check("idle_after_done", got, '0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0] as_i;
        logic       ad_i, cg_i, nwb_i;
        int         lat, pcs, wrs, rds;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int dc, np, nw, nr, nsl, nsi;
        vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0};
        vecs[1] = '{2'b10, 1'b0, 1'b0, 1'b0, 2, 0, 0, 1};
        vecs[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 2, 0, 0, 1};
        vecs[3] = '{2'b01, 1'b0, 1'b0, 1'b0, 3, 1, 0, 2};
        vecs[4] = '{2'b00, 1'b1, 1'b0, 1'b0, 4, 1, 1, 2};
        vecs[5] = '{2'b01, 1'b1, 1'b0, 1'b0, 6, 2, 1, 4};
        vecs[6] = '{2'b01, 1'b1, 1'b0, 1'b1, 5, 2, 0, 4};
        vecs[7] = '{2'b11, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0};
        vecs[8] = '{2'b10, 1'b1, 1'b0, 1'b1, 4, 1, 0, 3};
        vecs[9] = '{2'b00, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0};

        rst_n = 1'b0; start = 1'b0; As = '0; Ad = 0; cg = 0; no_wb = 0; mem_wait = 0;
        #12 check("reset_outputs", got, '0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_instr(vecs[i].as_i, vecs[i].ad_i, vecs[i].cg_i, vecs[i].nwb_i,
                      0, '0, 1'b0, 1'b1, 0, dc, np, nw, nr, nsl, nsi);
            check_int($sformatf("vec%0d_latency", i), dc, vecs[i].lat);
            check_int($sformatf("vec%0d_pc_inc", i), np, vecs[i].pcs);
            check_int($sformatf("vec%0d_mem_wr", i), nw, vecs[i].wrs);
            check_int($sformatf("vec%0d_mem_rd", i), nr, vecs[i].rds);
        end

        // @R4+ with three stall cycles in SRC_RD.
        run_instr(2'b11, 1'b0, 1'b0, 1'b0, 1, 32'b1110, 1'b0, 1'b0, 0,
                  dc, np, nw, nr, nsl, nsi);
        check_int("wait_src_rd_latency", dc, 5);
        check_int("wait_src_rd_srcl", nsl, 1);
        check_int("wait_src_rd_src_inc", nsi, 1);

        // Constant generator with start held high through the busy period.
        run_instr(2'b11, 1'b0, 1'b1, 1'b0, 0, '0, 1'b1, 1'b0, 0,
                  dc, np, nw, nr, nsl, nsi);
        check_int("cg_latency", dc, 1);
        check_int("cg_mem_rd", nr, 0);
        check_int("cg_src_inc", nsi, 0);

        // X(R5),Y(R6) aborted by reset during DST_RD (cycle 4), then a clean Rn,Rn.
        run_instr(2'b01, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 4,
                  dc, np, nw, nr, nsl, nsi);
        check_int("abort_no_done", dc, 0);
        run_instr(2'b00, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0,
                  dc, np, nw, nr, nsl, nsi);
        check_int("post_reset_latency", dc, 1);

        // Random instruction forms with random stalls and mid-instruction input noise.
        for (int i = 0; i < 40; i++) begin
            run_instr(2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      1'($urandom), 2, '0, 1'($urandom), 1'b1, 0,
                      dc, np, nw, nr, nsl, nsi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
